mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter sharing the single data-memory port of the `mipss` SoC between the MIPS core data side (port 0) and a second bus master such as a DMA or accelerator (port 1). It grants one access per cycle and supports locked bursts with a bounded length, so neither master can starve the other. Read data returns on a registered valid one cycle after the grant, matching the synchronous-read data memory.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `MAX_BURST`, default 4: maximum consecutive locked beats before forced rotation if the other port is waiting; must be ≥1.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  access request, held until granted.
- `lock0` / `lock1`  in  1  request to keep ownership after the current beat (burst).
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  AW  access address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  combinational grant; the access completes at the next rising edge.
- `rvalid0` / `rvalid1`  out  1  registered; read data valid for this port this cycle.
- `rdata`  out  DW  read data, shared by both ports; equals `mem_rdata`.
- `mem_en`  out  1  memory access this cycle (= `gnt0 | gnt1`).
- `mem_we`  out  1  muxed `we` of the granted port, gated by `mem_en`.
- `mem_addr`  out  AW  muxed address of the granted port; 0 when idle.
- `mem_wdata`  out  DW  muxed write data of the granted port; 0 when idle.
- `mem_rdata`  in  DW  memory read data; valid the cycle after a read access.

## Operation
- State:
  - `owner` ∈ {NONE, P0, P1}.
  - `last` (1 bit): port most recently released.
  - `beats` counter, width clog2(MAX_BURST+1).
- Arbitration when `owner` = NONE:
  - Only one `req` high: grant that port.
  - Both high: grant the port ≠ `last`.
  - Neither high: no grant; all `mem_*` outputs 0.
- Arbitration when `owner` = Pi:
  - Grant port i if `req_i` = 1; port j is never granted.
  - If `req_i` = 0: no grant this cycle, `owner` → NONE, `last` ← i. The released cycle is idle; the next grant comes a cycle later.
- Per granted beat on port i, at the clock edge:
  - `beats` ← `beats`+1.
  - Release (`owner` → NONE, `last` ← i, `beats` ← 0) if `lock_i` = 0, or if `beats`+1 = MAX_BURST and `req_j` = 1.
  - If `lock_i` = 1, `beats`+1 = MAX_BURST and `req_j` = 0: stay owner, `beats` ← 0 (burst continues).
  - Otherwise, if `lock_i` = 1: `owner` ← Pi.
- At most one `gnt` is high per cycle; `gnt0 & gnt1` = 0 is an invariant.
- `rvalid_i` ← `gnt_i & ~we_i`, registered. `rdata` = `mem_rdata` combinationally.
- Writes produce no response beyond `gnt`.
- `lock` is sampled only in granted cycles.

## Timing
- Grant latency: 0 cycles from `req` when the port is eligible. The `gnt` / `mem_*` path is combinational from `req`, `we`, `addr` and `wdata`.
- Read latency: `rvalid` one cycle after `gnt`.
- Back-to-back unlocked requests from both ports alternate every cycle: 0,1,0,1…
- Reset values: `owner` = NONE, `last` = 1 (port 0 wins the first tie), `beats` = 0, `rvalid0` = `rvalid1` = 0.
  - With `rst` high, all `gnt` and `mem_*` outputs are 0.
- Reset mid-burst or with a read outstanding: ownership is dropped and the pending `rvalid` is cleared immediately (asynchronous). No response is delivered after reset.
- `req` deasserted in the same cycle as `lock` = 1 on a granted beat: the beat completes; ownership is released the following cycle (see owner rule).

## Test plan
- Reset, then `req0` = 1 read with `addr0` = 0x10, memory returning 0xDEADBEEF:
  - `gnt0` = 1 in the same cycle.
  - `mem_addr` = 0x10, `mem_we` = 0.
  - Next cycle: `rvalid0` = 1, `rdata` = 0xDEADBEEF, `rvalid1` = 0.
- `req0` = `req1` = 1 continuously, no lock, from reset: grants go 0,1,0,1 over 4 cycles; `mem_addr` alternates `addr0` / `addr1`.
- `req1` + `lock1` held with `req0` idle for 10 cycles: `gnt1` stays high for all 10 cycles; `gnt0` never rises.
- `req0` + `lock0` held, `req1` raised during beat 2, MAX_BURST = 4:
  - `gnt0` for 4 beats total.
  - Then `gnt1` on the next cycle.
  - Then back to port 0 if `req1` is unlocked.
- Write from port 1 (`wdata1` = 0x12345678, `addr1` = 0x40) simultaneous with a read request on port 0 with `last` = 0:
  - Port 1 is granted first: `mem_we` = 1, `mem_wdata` = 0x12345678, no `rvalid1`.
  - Port 0 is granted the next cycle.
- Assert `rst` for 1 cycle in the cycle after a granted read mid-burst: `rvalid` is forced to 0, `owner` returns to NONE, and the next tie goes to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory port, with bounded locked bursts.
// Port 0 is the core data side; port 1 is a second bus master.

module mem_arbiter_port (
    input  logic clk,
    input  logic rst,
    input  logic gnt,
    input  logic we,
    output logic rvalid
);
    // Memory reads are synchronous, so data for a granted read lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid <= 1'b0;
        else     rvalid <= gnt & ~we;
    end
endmodule

module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int NUM_PORTS = 2;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

    typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

    owner_t  owner, owner_n;
    logic    last, last_n;
    logic [BW-1:0] beats, beats_n, beats_inc;

    logic [NUM_PORTS-1:0]         req, lock, we, gnt, rvalid_v;
    logic [NUM_PORTS-1:0][AW-1:0] addr;
    logic [NUM_PORTS-1:0][DW-1:0] wdata;

    logic gidx, glock, oreq;

    assign req   = {req1, req0};
    assign lock  = {lock1, lock0};
    assign we    = {we1, we0};
    assign addr  = {addr1, addr0};
    assign wdata = {wdata1, wdata0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
            last  <= 1'b1;
            beats <= '0;
        end else begin
            owner <= owner_n;
            last  <= last_n;
            beats <= beats_n;
        end
    end

    // Grant: an owner excludes the other port; otherwise a tie goes to the port not released last.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            case (owner)
                OWN_P0:  gnt[0] = req[0];
                OWN_P1:  gnt[1] = req[1];
                default: begin
                    gnt[0] = req[0] & (~req[1] | last);
                    gnt[1] = req[1] & (~req[0] | ~last);
                end
            endcase
        end
    end

    assign gidx      = gnt[1];
    assign glock     = gnt[1] ? lock[1] : lock[0];
    assign oreq      = gnt[1] ? req[0]  : req[1];
    assign beats_inc = beats + 1'b1;

    always_comb begin
        owner_n = owner;
        last_n  = last;
        beats_n = beats;
        if (|gnt) begin
            // Burst cap only forces a handover when the other port is actually waiting.
            if (!glock || (beats_inc == MAXB && oreq)) begin
                owner_n = OWN_NONE;
                last_n  = gidx;
                beats_n = '0;
            end else begin
                owner_n = gidx ? OWN_P1 : OWN_P0;
                beats_n = (beats_inc == MAXB) ? '0 : beats_inc;
            end
        end else if (owner != OWN_NONE) begin
            owner_n = OWN_NONE;
            last_n  = (owner == OWN_P1);
            beats_n = '0;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            mem_arbiter_port u_port (
                .clk    (clk),
                .rst    (rst),
                .gnt    (gnt[p]),
                .we     (we[p]),
                .rvalid (rvalid_v[p])
            );
        end
    endgenerate

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign rvalid0   = rvalid_v[0];
    assign rvalid1   = rvalid_v[1];
    assign rdata     = mem_rdata;
    assign mem_en    = |gnt;
    assign mem_we    = |(gnt & we);
    assign mem_addr  = gnt[1] ? addr[1]  : (gnt[0] ? addr[0]  : '0);
    assign mem_wdata = gnt[1] ? wdata[1] : (gnt[0] ? wdata[0] : '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, alternation, locked bursts, writes, mid-burst reset.

module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, lock0, lock1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    endtask

    initial begin
        logic exp0 [6];
        rst = 1; idle_all();
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;

        // Reset state; a request during reset must not be granted
        #2 req0 = 1;
        @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // Single read on port 0
        tick(); rst = 0; req0 = 1; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_gnt0", gnt0, 1);
        chk("rd_gnt1", gnt1, 0);
        chk("rd_addr", mem_addr, 32'h10);
        chk("rd_we", mem_we, 0);
        tick(); req0 = 0;
        @(negedge clk);
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_rvalid1", rvalid1, 0);
        chk("rd_idle_en", mem_en, 0);
        tick();
        @(negedge clk);
        chk("rd_rvalid0_drop", rvalid0, 0);

        // Alternation from reset: 0,1,0,1
        tick(); rst = 1;
        tick(); rst = 0; req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("alt_gnt0_%0d", i), gnt0, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("alt_gnt1_%0d", i), gnt1, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("alt_addr_%0d", i), mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            if (i == 2) chk("alt_rvalid1", rvalid1, 1);
            tick();
        end
        idle_all();
        @(negedge clk);
        chk("alt_idle", mem_en, 0);

        // Port 1 locked alone for 10 cycles, across burst wrap
        tick(); req1 = 1; lock1 = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("lk1_gnt1_%0d", i), gnt1, 1);
            chk($sformatf("lk1_gnt0_%0d", i), gnt0, 0);
            tick();
        end
        idle_all();
        @(negedge clk);
        chk("lk1_release", gnt1, 0);
        tick();

        // Port 0 locked burst, port 1 arrives on beat 2: 4 beats, then 1, then 0
        exp0 = '{1, 1, 1, 1, 0, 1};
        req0 = 1; lock0 = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) req1 = 1;
            @(negedge clk);
            chk($sformatf("burst_gnt0_%0d", i), gnt0, exp0[i]);
            chk($sformatf("burst_gnt1_%0d", i), gnt1, !exp0[i]);
            tick();
        end
        idle_all();
        @(negedge clk);
        chk("burst_release", mem_en, 0);
        tick();

        // last = 0 here: port 1 write wins the tie, port 0 read follows
        req1 = 1; we1 = 1; wdata1 = 32'h12345678; addr1 = 32'h40;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        @(negedge clk);
        chk("wr_gnt1", gnt1, 1);
        chk("wr_gnt0", gnt0, 0);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_wdata", mem_wdata, 32'h12345678);
        chk("wr_addr", mem_addr, 32'h40);
        tick(); req1 = 0; we1 = 0;
        @(negedge clk);
        chk("wr_then_gnt0", gnt0, 1);
        chk("wr_no_rvalid1", rvalid1, 0);
        chk("wr_then_addr", mem_addr, 32'h10);
        tick(); req0 = 0;
        @(negedge clk);
        chk("wr_rvalid0", rvalid0, 1);
        tick();

        // Reset right after a granted read in a locked burst (last = 0 beforehand)
        req0 = 1; lock0 = 1;
        tick();
        tick(); rst = 1;
        @(negedge clk);
        chk("mrst_rvalid0", rvalid0, 0);
        chk("mrst_gnt0", gnt0, 0);
        chk("mrst_mem_en", mem_en, 0);
        tick(); rst = 0; lock0 = 0; req1 = 1;
        @(negedge clk);
        chk("mrst_tie_gnt0", gnt0, 1);
        chk("mrst_tie_gnt1", gnt1, 0);
        chk("mrst_no_rvalid", rvalid0, 0);
        tick(); idle_all();
        @(negedge clk);
        chk("mrst_next_gnt1", gnt1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
